// File: rtl/cordic_atanh_seq.sv
// Sequential hyperbolic-vectoring CORDIC computing atanh(v) in fp32.
// One guarded fp32 adder is shared by the x, y and z updates, one update per cycle.
module cordic_atanh_seq #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in_v,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        invalid
);
  typedef enum logic [2:0] {IDLE, CHECK, XSTEP, YSTEP, ZSTEP, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] v_q, x, y, z, xt;
  logic [4:0]  k, idx;
  logic        neg;
  logic [31:0] op_a, op_b, sum;
  logic        last;

  // Shift index sequence 1,2,3,4,4,5,...,13,13,14,...
  function automatic logic [4:0] shift_idx(input logic [4:0] kk);
    if (kk < 5'd4)       return kk + 5'd1;
    else if (kk < 5'd14) return kk;
    else                 return kk - 5'd1;
  endfunction

  function automatic logic [31:0] scale(input logic [31:0] v, input logic [4:0] i);
    if (v[30:23] <= {3'b000, i}) return 32'd0;
    return {v[31], v[30:23] - {3'b000, i}, v[22:0]};
  endfunction

  // atanh(2^-i); beyond i=11 the cubic term falls below half an ulp
  function automatic logic [31:0] atanh_rom(input logic [4:0] i);
    case (i)
      5'd1:  return 32'h3F0C9F54;
      5'd2:  return 32'h3E82C578;
      5'd3:  return 32'h3E00AC49;
      5'd4:  return 32'h3D802AC4;
      5'd5:  return 32'h3D000AAC;
      5'd6:  return 32'h3C8002AB;
      5'd7:  return 32'h3C0000AB;
      5'd8:  return 32'h3B80002B;
      5'd9:  return 32'h3B00000B;
      5'd10: return 32'h3A800003;
      5'd11: return 32'h3A000001;
      default: return {1'b0, 8'd127 - {3'b000, i}, 23'd0};
    endcase
  endfunction

  // Normal-operand fp32 add, truncating; zero operands are handled by the guard
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       hi, lo;
    logic [7:0]        d;
    logic [26:0]       mh, ml;
    logic [27:0]       s;
    logic signed [9:0] e;
    if (a[30:0] >= b[30:0]) begin hi = a; lo = b; end
    else                    begin hi = b; lo = a; end
    d  = hi[30:23] - lo[30:23];
    mh = {1'b1, hi[22:0], 3'b000};
    ml = (d > 8'd26) ? 27'd0 : ({1'b1, lo[22:0], 3'b000} >> d);
    e  = signed'({2'b00, hi[30:23]});
    if (hi[31] == lo[31]) s = {1'b0, mh} + {1'b0, ml};
    else                  s = {1'b0, mh} - {1'b0, ml};
    if (s[27]) begin
      s = s >> 1;
      e = e + 10'sd1;
    end else begin
      for (int n = 0; n < 27; n++)
        if (!s[26] && s != 28'd0) begin
          s = s << 1;
          e = e - 10'sd1;
        end
    end
    if (s == 28'd0 || e <= 10'sd0) return 32'd0;
    return {hi[31], e[7:0], s[25:3]};
  endfunction

  assign idx  = shift_idx(k);
  assign last = (k == 5'(ITER - 1));
  assign busy = (state == CHECK) || (state == XSTEP) || (state == YSTEP) || (state == ZSTEP);
  assign done = (state == DONE);

  // Operand sequencing; sigma is applied as a sign flip
  always_comb begin
    op_a = z;
    op_b = 32'd0;
    case (state)
      XSTEP: begin op_a = x; op_b = scale(y, idx) ^ {~y[31], 31'd0}; end
      YSTEP: begin op_a = y; op_b = scale(x, idx) ^ {~neg, 31'd0}; end
      ZSTEP: begin op_a = z; op_b = atanh_rom(idx) ^ {neg, 31'd0}; end
      default: ;
    endcase
  end

  always_comb begin
    if (op_a[30:23] == 8'd0)      sum = op_b;
    else if (op_b[30:23] == 8'd0) sum = op_a;
    else if (op_a[30:0] == op_b[30:0] && op_a[31] != op_b[31]) sum = 32'd0;
    else                          sum = fp_add(op_a, op_b);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = CHECK;
      CHECK: state_nx = (v_q[30:23] >= 8'd127 || v_q[30:23] == 8'd0) ? DONE : XSTEP;
      XSTEP: state_nx = YSTEP;
      YSTEP: state_nx = ZSTEP;
      ZSTEP: state_nx = last ? DONE : XSTEP;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      v_q     <= 32'd0;
      x       <= 32'd0;
      y       <= 32'd0;
      z       <= 32'd0;
      xt      <= 32'd0;
      k       <= 5'd0;
      neg     <= 1'b0;
      result  <= 32'd0;
      invalid <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) v_q <= in_v;
        CHECK: begin
          if (v_q[30:23] >= 8'd127) begin
            result  <= 32'h7FC00000;
            invalid <= 1'b1;
          end else if (v_q[30:23] == 8'd0) begin
            result  <= {v_q[31], 31'd0};
            invalid <= 1'b0;
          end else begin
            x <= 32'h3F800000;
            y <= v_q;
            z <= 32'd0;
            k <= 5'd0;
          end
        end
        // direction is frozen here so y and z updates of this iteration agree
        XSTEP: begin xt <= sum; neg <= y[31]; end
        YSTEP: y <= sum;
        ZSTEP: begin
          z <= sum;
          x <= xt;
          k <= k + 5'd1;
          if (last) begin
            result  <= sum;
            invalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
